// File: rtl/branch_predictor_table_pkg.sv
// -----------------------------------------------------------------------------
// branch_predictor_table_pkg
// Shared definitions for the dynamic branch predictor:
//   - bp_idx_f        : PHT index hash (PC bits, optionally XOR-ed with history)
//   - bp_wnt_f        : weakly-not-taken reset value for a given counter width
//   - bp_sat_inc_f /
//     bp_sat_dec_f    : saturating counter step functions
//   - bp_btb_entry_t  : BTB entry (valid, tag, target)
// Values are carried at a fixed maximum width. Each user truncates the result to
// its own parameterised width.
// -----------------------------------------------------------------------------
package branch_predictor_table_pkg;

  localparam int BP_MAX_W        = 32;  // widest PC / target / tag handled
  localparam int BP_CTR_MAX_BITS = 3;   // widest saturating counter handled

  typedef logic [BP_CTR_MAX_BITS-1:0] bp_ctr_t;

  typedef struct packed {
    logic                valid;
    logic [BP_MAX_W-1:0] tag;     // pc >> (IDX+2), zero-extended
    logic [BP_MAX_W-1:0] target;
  } bp_btb_entry_t;

  // Index = pc[idx_bits+1:2] ^ {ghr, zeros}. The history lands in the top
  // hist_bits of the index. hist_bits = 0 gives the plain bimodal index.
  function automatic logic [BP_MAX_W-1:0] bp_idx_f(
    input logic [BP_MAX_W-1:0] pc,
    input logic [BP_MAX_W-1:0] ghr,
    input int                  idx_bits,
    input int                  hist_bits
  );
    logic [BP_MAX_W-1:0] mask;
    logic [BP_MAX_W-1:0] idx;
    mask = (BP_MAX_W'(1) << idx_bits) - BP_MAX_W'(1);
    idx  = (pc >> 2) & mask;
    if (hist_bits > 0) begin
      idx = idx ^ ((ghr << (idx_bits - hist_bits)) & mask);
    end
    return idx;
  endfunction

  // Weakly-not-taken: 2^(bits-1) - 1. For a 1-bit counter this value is 0.
  function automatic bp_ctr_t bp_wnt_f(input int bits);
    return bp_ctr_t'((1 << (bits - 1)) - 1);
  endfunction

  function automatic bp_ctr_t bp_ctr_max_f(input int bits);
    return bp_ctr_t'((1 << bits) - 1);
  endfunction

  function automatic bp_ctr_t bp_sat_inc_f(input bp_ctr_t ctr, input int bits);
    return (ctr >= bp_ctr_max_f(bits)) ? ctr : ctr + bp_ctr_t'(1);
  endfunction

  function automatic bp_ctr_t bp_sat_dec_f(input bp_ctr_t ctr);
    return (ctr == '0) ? ctr : ctr - bp_ctr_t'(1);
  endfunction

endpackage

// File: rtl/branch_predictor_table_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// One PHT entry: an up/down counter that saturates at both ends.
// Ports:
//   clk  : clock
//   rst  : synchronous active-low reset, loads weakly-not-taken
//   en   : apply one step this cycle
//   dir  : 1 = increment (taken), 0 = decrement (not taken)
//   ctr  : current counter value
// -----------------------------------------------------------------------------
module sat_counter
  import branch_predictor_table_pkg::*;
#(
  parameter int CTR_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                dir,
  output logic [CTR_BITS-1:0] ctr
);

  logic [CTR_BITS-1:0] ctr_q;
  logic [CTR_BITS-1:0] ctr_d;
  bp_ctr_t             ctr_ext;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    ctr_ext = bp_ctr_t'(ctr_q);
    ctr_d   = ctr_q;
    if (en) begin
      ctr_d = dir ? CTR_BITS'(bp_sat_inc_f(ctr_ext, CTR_BITS))
                  : CTR_BITS'(bp_sat_dec_f(ctr_ext));
    end
  end

  // NOTE: state is written with non-blocking assignments, so every flop samples
  // the pre-edge values and the order of the blocks does not matter.
  always_ff @(posedge clk) begin
    if (!rst) ctr_q <= CTR_BITS'(bp_wnt_f(CTR_BITS));
    else      ctr_q <= ctr_d;
  end

  assign ctr = ctr_q;

endmodule

// File: rtl/branch_predictor_table.sv
// -----------------------------------------------------------------------------
// branch_predictor_table
// PC-indexed pattern history table of saturating counters, with optional gshare
// history hashing. Gives a same-cycle prediction for the instruction in IF and
// is trained from ID when a branch resolves.
// Define BP_BTB_EN to add a branch target buffer that drives pred_hit and
// pred_target. Without it both outputs are tied to 0 and upd_target is unused.
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   if_pc         : PC in IF (lookup, combinational)
//   pred_taken    : MSB of the indexed counter
//   pred_idx      : PHT index used; the pipeline carries it to the update
//   pred_hit      : BTB holds a valid, tag-matching target for if_pc
//   pred_target   : BTB target (0 when there is no hit)
//   upd_valid     : a branch resolved this cycle
//   upd_idx       : pred_idx carried with that branch
//   upd_pc        : PC of the resolved branch
//   upd_taken     : actual outcome
//   upd_target    : actual taken target
// -----------------------------------------------------------------------------
module branch_predictor_table
  import branch_predictor_table_pkg::*;
#(
  parameter  int WIDTH     = 32,
  parameter  int ENTRIES   = 64,
  parameter  int CTR_BITS  = 2,
  parameter  int HIST_BITS = 0,
  localparam int IDX       = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] if_pc,
  output logic             pred_taken,
  output logic [IDX-1:0]   pred_idx,
  output logic             pred_hit,
  output logic [WIDTH-1:0] pred_target,
  input  logic             upd_valid,
  input  logic [IDX-1:0]   upd_idx,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic             upd_taken,
  input  logic [WIDTH-1:0] upd_target
);

  // One history flop is kept even in bimodal mode. It is held at zero there, so
  // the width is never 0.
  localparam int GW = (HIST_BITS > 0) ? HIST_BITS : 1;

  logic [GW-1:0]       ghr_q;
  logic [GW-1:0]       ghr_d;
  logic [CTR_BITS-1:0] ctr [ENTRIES];
  logic [IDX-1:0]      lkp_idx;   // history-hashed lookup index
  logic [IDX-1:0]      pc_idx;    // pure PC index (reset output, BTB index)
  logic [BP_MAX_W-1:0] if_pc_w;

  assign if_pc_w = BP_MAX_W'(if_pc);
  assign lkp_idx = IDX'(bp_idx_f(if_pc_w, BP_MAX_W'(ghr_q), IDX, HIST_BITS));
  assign pc_idx  = IDX'(bp_idx_f(if_pc_w, '0, IDX, 0));

  // While reset is held, outputs show the documented reset view. This hides
  // history and counter state that the first reset edge has not loaded yet.
  assign pred_idx   = rst ? lkp_idx : pc_idx;
  assign pred_taken = rst && ctr[lkp_idx][CTR_BITS-1];

  // Pattern history table. A lookup of the entry being updated in the same
  // cycle returns the old value, because no bypass is added.
  for (genvar i = 0; i < ENTRIES; i++) begin : g_pht
    sat_counter #(
      .CTR_BITS (CTR_BITS)
    ) u_ctr (
      .clk (clk),
      .rst (rst),
      .en  (upd_valid && (upd_idx == IDX'(i))),
      .dir (upd_taken),
      .ctr (ctr[i])
    );
  end

  // Global history is non-speculative and shifts only when a branch resolves.
  always_comb begin
    ghr_d = ghr_q;
    if (HIST_BITS == 0) begin
      ghr_d = '0;
    end else if (upd_valid) begin
      ghr_d = GW'({ghr_q, upd_taken});
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) ghr_q <= '0;
    else      ghr_q <= ghr_d;
  end

`ifdef BP_BTB_EN
  bp_btb_entry_t       btb_q [ENTRIES];
  bp_btb_entry_t       rd_entry;
  bp_btb_entry_t       wr_entry;
  logic                btb_hit;
  logic                btb_we;
  logic [IDX-1:0]      wr_idx;
  logic [BP_MAX_W-1:0] upd_pc_w;

  assign upd_pc_w = BP_MAX_W'(upd_pc);

  always_comb begin
    rd_entry        = btb_q[pc_idx];
    btb_hit         = rd_entry.valid && (rd_entry.tag == (if_pc_w >> (IDX + 2)));
    wr_idx          = IDX'(bp_idx_f(upd_pc_w, '0, IDX, 0));
    btb_we          = upd_valid && upd_taken;
    wr_entry.valid  = 1'b1;
    wr_entry.tag    = upd_pc_w >> (IDX + 2);
    wr_entry.target = BP_MAX_W'(upd_target);
  end

  // NOTE: reset clears only the valid bits. Tag and target are never read
  // while valid is 0, so those storage bits need no reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) btb_q[i].valid <= 1'b0;
    end else if (btb_we) begin
      btb_q[wr_idx] <= wr_entry;
    end
  end

  assign pred_hit    = rst && btb_hit;
  assign pred_target = pred_hit ? WIDTH'(rd_entry.target) : '0;
`else
  logic unused_btb_inputs;
  assign unused_btb_inputs = ^{upd_pc, upd_target};
  assign pred_hit          = 1'b0;
  assign pred_target       = '0;
`endif

endmodule

// File: tb/tb_branch_predictor_table.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor_table
// Drives a bimodal instance (HIST_BITS=0) and a gshare instance (HIST_BITS=2),
// both with 16 entries and 2-bit counters, from one shared update stream.
// Outputs are compared with a reference model of counters, history and BTB.
// -----------------------------------------------------------------------------
module tb_branch_predictor_table;

  localparam int N = 16;
`ifdef BP_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] if_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [3:0]  bim_upd_idx, gsh_upd_idx;

  logic        bim_taken, bim_hit, gsh_taken, gsh_hit;
  logic [3:0]  bim_idx, gsh_idx;
  logic [31:0] bim_target, gsh_target;

  branch_predictor_table #(.WIDTH(32), .ENTRIES(N), .CTR_BITS(2), .HIST_BITS(0)) u_bim (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(bim_taken), .pred_idx(bim_idx), .pred_hit(bim_hit), .pred_target(bim_target),
    .upd_valid(upd_valid), .upd_idx(bim_upd_idx), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target)
  );

  branch_predictor_table #(.WIDTH(32), .ENTRIES(N), .CTR_BITS(2), .HIST_BITS(2)) u_gsh (
    .clk(clk), .rst(rst), .if_pc(if_pc),
    .pred_taken(gsh_taken), .pred_idx(gsh_idx), .pred_hit(gsh_hit), .pred_target(gsh_target),
    .upd_valid(upd_valid), .upd_idx(gsh_upd_idx), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target)
  );

  // Reference model
  int          bim_ctr [N];
  int          gsh_ctr [N];
  int          gsh_ghr;
  bit          bv      [N];
  int unsigned btag    [N];
  int unsigned btgt    [N];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic int m_idx(input int unsigned pc, input int ghr, input int hist);
    int i;
    i = int'((pc / 4) % N);
    if (hist > 0) i = i ^ ((ghr * (N >> hist)) % N);
    return i;
  endfunction

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : (v > 3) ? 3 : v;
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
  endtask

  task automatic check_all(input string tag);
    int          bi, gi, b;
    logic [31:0] e_bt, e_gt, e_hit, e_tgt;
    bi = m_idx(if_pc, 0, 0);
    gi = m_idx(if_pc, gsh_ghr, 2);
    b  = bi;
    if (!rst) begin
      gi = bi; e_bt = 0; e_gt = 0; e_hit = 0; e_tgt = 0;
    end else begin
      e_bt  = (bim_ctr[bi] >= 2) ? 32'd1 : 32'd0;
      e_gt  = (gsh_ctr[gi] >= 2) ? 32'd1 : 32'd0;
      e_hit = (BTB_ON && bv[b] && btag[b] == if_pc / 64) ? 32'd1 : 32'd0;
      e_tgt = (e_hit != 0) ? btgt[b] : 32'd0;
    end
    check({tag, "/bim_idx"},   32'(bim_idx),   32'(bi));
    check({tag, "/gsh_idx"},   32'(gsh_idx),   32'(gi));
    check({tag, "/bim_taken"}, 32'(bim_taken), e_bt);
    check({tag, "/gsh_taken"}, 32'(gsh_taken), e_gt);
    check({tag, "/bim_hit"},   32'(bim_hit),   e_hit);
    check({tag, "/gsh_hit"},   32'(gsh_hit),   e_hit);
    check({tag, "/bim_tgt"},   bim_target,     e_tgt);
    check({tag, "/gsh_tgt"},   gsh_target,     e_tgt);
  endtask

  // One rising edge: the model absorbs the inputs seen at that edge, then the
  // bench returns to the falling edge to drive the next step.
  task automatic tick();
    int b;
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        bim_ctr[i] = 1; gsh_ctr[i] = 1; bv[i] = 1'b0;
      end
      gsh_ghr = 0;
    end else if (upd_valid) begin
      bim_ctr[bim_upd_idx] = clamp(bim_ctr[bim_upd_idx] + (upd_taken ? 1 : -1));
      gsh_ctr[gsh_upd_idx] = clamp(gsh_ctr[gsh_upd_idx] + (upd_taken ? 1 : -1));
      gsh_ghr = (gsh_ghr * 2 + int'(upd_taken)) % 4;
      if (upd_taken) begin
        b = int'((upd_pc / 4) % N);
        bv[b] = 1'b1; btag[b] = upd_pc / 64; btgt[b] = upd_target;
      end
    end
    @(negedge clk);
  endtask

  // Resolve a branch at pc. gidx < 0 means the gshare index carried from the
  // lookup (history at this time); otherwise it is forced.
  task automatic upd(input string tag, input logic [31:0] ifpc, input logic [31:0] pc,
                     input logic taken, input logic [31:0] tgt, input int gidx);
    if_pc       = ifpc;
    upd_valid   = 1'b1;
    upd_pc      = pc;
    upd_taken   = taken;
    upd_target  = tgt;
    bim_upd_idx = 4'(m_idx(pc, 0, 0));
    gsh_upd_idx = (gidx < 0) ? 4'(m_idx(pc, gsh_ghr, 2)) : 4'(gidx);
    #1 check_all(tag);
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] ifpc);
    if_pc     = ifpc;
    upd_valid = 1'b0;
    #1 check_all(tag);
  endtask

  initial begin
    logic        t0;
    logic [31:0] pc0;
    rst = 1'b0; if_pc = '0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_target = '0; bim_upd_idx = '0; gsh_upd_idx = '0;

    // Reset state: outputs while reset is held, then sweep after release
    @(negedge clk);
    look("in_reset", 32'h34);
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      look("rst_sweep", 32'(i * 4));
      check("rst_idx", 32'(bim_idx), 32'(i));
    end

    // Bimodal training on 0x100 (index 0)
    upd("bim_t1", 32'h100, 32'h100, 1'b1, 32'h0, -1);
    look("bim_after_t1", 32'h100);
    check("bim_1T_taken", 32'(bim_taken), 32'd1);
    for (int i = 0; i < 3; i++) upd("bim_tsat", 32'h100, 32'h100, 1'b1, 32'h0, -1);
    upd("bim_n1", 32'h100, 32'h100, 1'b0, 32'h0, -1);
    look("bim_after_n1", 32'h100);
    check("bim_sat_taken", 32'(bim_taken), 32'd1);
    upd("bim_n2", 32'h100, 32'h100, 1'b0, 32'h0, -1);
    look("bim_after_n2", 32'h100);
    check("bim_2N_taken", 32'(bim_taken), 32'd0);

    // Aliasing: 0x140 shares index 0; same-cycle read sees the old value
    if_pc = 32'h100; upd_valid = 1'b1; upd_pc = 32'h140; upd_taken = 1'b1;
    upd_target = 32'h0; bim_upd_idx = 4'(m_idx(32'h140, 0, 0));
    gsh_upd_idx = 4'(m_idx(32'h140, gsh_ghr, 2));
    #1 check("alias_old", 32'(bim_taken), 32'd0);
    check_all("alias_same");
    tick();
    upd_valid = 1'b0;
    #1 check("alias_new", 32'(bim_taken), 32'd1);

    // Gshare: outcomes T,N leave history 2'b10
    upd("gsh_t", 32'h3c, 32'h3c, 1'b1, 32'h0, -1);
    upd("gsh_n", 32'h3c, 32'h3c, 1'b0, 32'h0, -1);
    look("gsh_hist10", 32'h0);
    check("gsh_idx8", 32'(gsh_idx), 32'd8);
    look("gsh_idx0_pre", 32'h20);
    check("gsh_idx0", 32'(gsh_idx), 32'd0);
    t0 = gsh_taken;
    upd("gsh_tr8a", 32'h0, 32'h0, 1'b1, 32'h0, 8);
    upd("gsh_tr8b", 32'h0, 32'h0, 1'b1, 32'h0, 8);
    pc0 = 32'(((gsh_ghr * 4) % N) * 4);
    look("gsh_idx0_post", pc0);
    check("gsh_iso_idx", 32'(gsh_idx), 32'd0);
    check("gsh_iso_taken", 32'(gsh_taken), 32'(t0));

    // BTB
    upd("btb_wr", 32'h200, 32'h200, 1'b1, 32'h3f0, -1);
    look("btb_hit", 32'h200);
    check("btb_hit", 32'(bim_hit), 32'(BTB_ON));
    check("btb_tgt", bim_target, BTB_ON ? 32'h3f0 : 32'h0);
    look("btb_tagmiss", 32'h600);
    check("btb_tagmiss", 32'(bim_hit), 32'd0);
    upd("btb_nt", 32'h200, 32'h200, 1'b0, 32'h123, -1);
    look("btb_keep", 32'h200);
    check("btb_keep_hit", 32'(bim_hit), 32'(BTB_ON));
    check("btb_keep_tgt", bim_target, BTB_ON ? 32'h3f0 : 32'h0);

    // Reset overrides a same-cycle taken update
    rst = 1'b0; if_pc = 32'h100; upd_valid = 1'b1; upd_pc = 32'h100;
    upd_taken = 1'b1; upd_target = 32'h55; bim_upd_idx = 4'd0; gsh_upd_idx = 4'd0;
    #1 check_all("rst_mid");
    tick();
    rst = 1'b1; upd_valid = 1'b0;
    look("rst_mid_after", 32'h100);
    check("rst_mid_taken", 32'(bim_taken), 32'd0);
    check("rst_mid_hit", 32'(bim_hit), 32'd0);
    upd("rst_mid_t", 32'h100, 32'h100, 1'b1, 32'h44, -1);
    look("rst_mid_t_after", 32'h100);
    check("rst_mid_ctr01", 32'(bim_taken), 32'd1);

    // Randomised traffic, occasional reset
    for (int c = 0; c < 400; c++) begin
      rst         = ($urandom_range(0, 63) != 0);
      if_pc       = 32'($urandom_range(0, 1023)) << 2;
      upd_valid   = ($urandom_range(0, 2) != 0);
      upd_pc      = 32'($urandom_range(0, 63)) << 2;
      upd_taken   = 1'($urandom_range(0, 1));
      upd_target  = $urandom;
      bim_upd_idx = 4'(m_idx(upd_pc, 0, 0));
      gsh_upd_idx = 4'(m_idx(upd_pc, gsh_ghr, 2));
      #1 check_all("rand");
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
